// File: rtl/instr_register_alu_if.sv
// Bus bundle for instr_register_alu: load request, read request and registered read data.
// The master side drives loads/reads; the slave side is the register file.
interface instr_register_alu_if #(
   parameter int DEPTH     = 32,
   parameter int OPERAND_W = 32
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic                   load_en;
   logic [3:0]             opcode;
   logic [OPERAND_W-1:0]   operand_a;
   logic [OPERAND_W-1:0]   operand_b;
   logic [AW-1:0]          write_pointer;
   logic                   read_en;
   logic [AW-1:0]          read_pointer;
   logic                   rd_valid;
   logic [3:0]             rd_opcode;
   logic [OPERAND_W-1:0]   rd_operand_a;
   logic [OPERAND_W-1:0]   rd_operand_b;
   logic [2*OPERAND_W-1:0] rd_result;
   logic                   rd_err;
   logic [CW-1:0]          valid_count;

   modport master (
      output load_en, opcode, operand_a, operand_b, write_pointer, read_en, read_pointer,
      input  rd_valid, rd_opcode, rd_operand_a, rd_operand_b, rd_result, rd_err, valid_count
   );

   modport slave (
      input  load_en, opcode, operand_a, operand_b, write_pointer, read_en, read_pointer,
      output rd_valid, rd_opcode, rd_operand_a, rd_operand_b, rd_result, rd_err, valid_count
   );
endinterface

// File: rtl/instr_register_alu.sv
// DEPTH-entry instruction register with a one-stage load pipeline and registered read port.
// Define INSTR_REG_RESULT_EN to include the signed ALU and result/err storage.
module instr_register_alu #(
   parameter int DEPTH     = 32,
   parameter int OPERAND_W = 32
) (
   input logic                clk,
   input logic                reset,
   instr_register_alu_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int RW = 2 * OPERAND_W;

   logic                 s1_vld_q;
   logic [AW-1:0]        s1_ptr_q;
   logic [3:0]           s1_op_q;
   logic [OPERAND_W-1:0] s1_a_q;
   logic [OPERAND_W-1:0] s1_b_q;

   logic [DEPTH-1:0]     valid_q;
   logic [CW-1:0]        cnt_q;

   logic [3:0]           op_mem [DEPTH];
   logic [OPERAND_W-1:0] a_mem  [DEPTH];
   logic [OPERAND_W-1:0] b_mem  [DEPTH];

   logic                 rd_valid_q, rd_valid_d;
   logic [3:0]           rd_op_q,    rd_op_d;
   logic [OPERAND_W-1:0] rd_a_q,     rd_a_d;
   logic [OPERAND_W-1:0] rd_b_q,     rd_b_d;

   logic                 hit;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_vld_q <= 1'b0;
         s1_ptr_q <= '0;
         s1_op_q  <= '0;
         s1_a_q   <= '0;
         s1_b_q   <= '0;
      end else begin
         s1_vld_q <= bus.load_en;
         if (bus.load_en) begin
            s1_ptr_q <= bus.write_pointer;
            s1_op_q  <= bus.opcode;
            s1_a_q   <= bus.operand_a;
            s1_b_q   <= bus.operand_b;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q <= '0;
         cnt_q   <= '0;
      end else if (s1_vld_q) begin
         valid_q[s1_ptr_q] <= 1'b1;
         if (!valid_q[s1_ptr_q]) cnt_q <= cnt_q + CW'(1);
      end
   end

   // Payloads are never reset; valid_q masks stale contents.
   always_ff @(posedge clk) begin
      if (s1_vld_q) begin
         op_mem[s1_ptr_q] <= s1_op_q;
         a_mem[s1_ptr_q]  <= s1_a_q;
         b_mem[s1_ptr_q]  <= s1_b_q;
      end
   end

   assign hit = s1_vld_q && (s1_ptr_q == bus.read_pointer);

   always_comb begin
      rd_valid_d = rd_valid_q;
      rd_op_d    = rd_op_q;
      rd_a_d     = rd_a_q;
      rd_b_d     = rd_b_q;
      if (bus.read_en) begin
         if (hit) begin
            rd_valid_d = 1'b1;
            rd_op_d    = s1_op_q;
            rd_a_d     = s1_a_q;
            rd_b_d     = s1_b_q;
         end else if (valid_q[bus.read_pointer]) begin
            rd_valid_d = 1'b1;
            rd_op_d    = op_mem[bus.read_pointer];
            rd_a_d     = a_mem[bus.read_pointer];
            rd_b_d     = b_mem[bus.read_pointer];
         end else begin
            rd_valid_d = 1'b0;
            rd_op_d    = '0;
            rd_a_d     = '0;
            rd_b_d     = '0;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_valid_q <= 1'b0;
         rd_op_q    <= '0;
         rd_a_q     <= '0;
         rd_b_q     <= '0;
      end else begin
         rd_valid_q <= rd_valid_d;
         rd_op_q    <= rd_op_d;
         rd_a_q     <= rd_a_d;
         rd_b_q     <= rd_b_d;
      end
   end

`ifdef INSTR_REG_RESULT_EN
   logic signed [RW-1:0] ext_a, ext_b, alu_res;
   logic                 alu_err;
   logic [RW-1:0]        res_mem [DEPTH];
   logic                 err_mem [DEPTH];
   logic [RW-1:0]        rd_res_q, rd_res_d;
   logic                 rd_err_q, rd_err_d;

   // Both operands are W-bit values widened to 2W, so no opcode can overflow.
   always_comb begin
      ext_a   = {{OPERAND_W{s1_a_q[OPERAND_W-1]}}, s1_a_q};
      ext_b   = {{OPERAND_W{s1_b_q[OPERAND_W-1]}}, s1_b_q};
      alu_res = '0;
      alu_err = 1'b0;
      case (s1_op_q)
         4'd0: alu_res = '0;
         4'd1: alu_res = ext_a;
         4'd2: alu_res = ext_b;
         4'd3: alu_res = ext_a + ext_b;
         4'd4: alu_res = ext_a - ext_b;
         4'd5: alu_res = ext_a * ext_b;
         4'd6: begin
            if (ext_b == '0) alu_err = 1'b1;
            else             alu_res = ext_a / ext_b;
         end
         4'd7: begin
            if (ext_b == '0) alu_err = 1'b1;
            else             alu_res = ext_a % ext_b;
         end
         default: alu_err = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (s1_vld_q) begin
         res_mem[s1_ptr_q] <= alu_res;
         err_mem[s1_ptr_q] <= alu_err;
      end
   end

   always_comb begin
      rd_res_d = rd_res_q;
      rd_err_d = rd_err_q;
      if (bus.read_en) begin
         if (hit) begin
            rd_res_d = alu_res;
            rd_err_d = alu_err;
         end else if (valid_q[bus.read_pointer]) begin
            rd_res_d = res_mem[bus.read_pointer];
            rd_err_d = err_mem[bus.read_pointer];
         end else begin
            rd_res_d = '0;
            rd_err_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_res_q <= '0;
         rd_err_q <= 1'b0;
      end else begin
         rd_res_q <= rd_res_d;
         rd_err_q <= rd_err_d;
      end
   end

   assign bus.rd_result = rd_res_q;
   assign bus.rd_err    = rd_err_q;
`else
   assign bus.rd_result = '0;
   assign bus.rd_err    = 1'b0;
`endif

   assign bus.rd_valid     = rd_valid_q;
   assign bus.rd_opcode    = rd_op_q;
   assign bus.rd_operand_a = rd_a_q;
   assign bus.rd_operand_b = rd_b_q;
   assign bus.valid_count  = cnt_q;
endmodule

// File: tb/tb_instr_register_alu.sv
// Directed bench for instr_register_alu (DEPTH=32, OPERAND_W=32).
// Result/err expectations collapse to 0 when INSTR_REG_RESULT_EN is undefined.
module tb_instr_register_alu;
   logic clk;
   logic reset;
   int   n_vec = 0;
   int   n_bad = 0;

   instr_register_alu_if #(.DEPTH(32), .OPERAND_W(32)) bus ();

   instr_register_alu #(.DEPTH(32), .OPERAND_W(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] exp_res(input logic [63:0] v);
`ifdef INSTR_REG_RESULT_EN
      return v;
`else
      return 64'd0 & v;
`endif
   endfunction

   function automatic logic exp_err(input logic e);
`ifdef INSTR_REG_RESULT_EN
      return e;
`else
      return 1'b0 & e;
`endif
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] ptr);
      bus.load_en       = 1'b1;
      bus.opcode        = op;
      bus.operand_a     = a;
      bus.operand_b     = b;
      bus.write_pointer = ptr;
      step();
      bus.load_en = 1'b0;
   endtask

   task automatic rd(input logic [4:0] ptr);
      bus.read_en      = 1'b1;
      bus.read_pointer = ptr;
      step();
      bus.read_en = 1'b0;
   endtask

   task automatic chk_entry(input string tag, input logic [3:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [63:0] res, input logic err);
      chk({tag, ".valid"}, {63'd0, bus.rd_valid}, 64'd1);
      chk({tag, ".op"},    {60'd0, bus.rd_opcode}, {60'd0, op});
      chk({tag, ".a"},     {32'd0, bus.rd_operand_a}, {32'd0, a});
      chk({tag, ".b"},     {32'd0, bus.rd_operand_b}, {32'd0, b});
      chk({tag, ".res"},   bus.rd_result, exp_res(res));
      chk({tag, ".err"},   {63'd0, bus.rd_err}, {63'd0, exp_err(err)});
   endtask

   task automatic chk_empty(input string tag);
      chk({tag, ".valid"}, {63'd0, bus.rd_valid}, 64'd0);
      chk({tag, ".op"},    {60'd0, bus.rd_opcode}, 64'd0);
      chk({tag, ".a"},     {32'd0, bus.rd_operand_a}, 64'd0);
      chk({tag, ".b"},     {32'd0, bus.rd_operand_b}, 64'd0);
      chk({tag, ".res"},   bus.rd_result, 64'd0);
      chk({tag, ".err"},   {63'd0, bus.rd_err}, 64'd0);
   endtask

   task automatic chk_cnt(input string tag, input int exp);
      chk(tag, {58'd0, bus.valid_count}, 64'(exp));
   endtask

   initial begin
      reset             = 1'b1;
      bus.load_en       = 1'b0;
      bus.opcode        = 4'd0;
      bus.operand_a     = 32'd0;
      bus.operand_b     = 32'd0;
      bus.write_pointer = 5'd0;
      bus.read_en       = 1'b0;
      bus.read_pointer  = 5'd0;

      #12;
      chk_empty("rst");
      chk_cnt("rst.cnt", 0);
      #5 reset = 1'b0;
      step();

      // Load captured into S1, then reset before it can commit.
      load(4'd3, 32'd1, 32'd1, 5'd7);
      #2 reset = 1'b1;
      #1;
      chk_cnt("midrst.cnt_async", 0);
      #1 reset = 1'b0;
      rd(5'd7);
      chk_empty("midrst.e7");
      chk_cnt("midrst.cnt", 0);

      load(4'd3, 32'd5, 32'hFFFF_FFFD, 5'd2);
      rd(5'd2);
      chk_entry("add", 4'd3, 32'd5, 32'hFFFF_FFFD, 64'd2, 1'b0);
      chk_cnt("add.cnt", 1);

      load(4'd5, 32'h7FFF_FFFF, 32'd2, 5'd10);
      rd(5'd10);
      chk_entry("mult", 4'd5, 32'h7FFF_FFFF, 32'd2, 64'h0000_0000_FFFF_FFFE, 1'b0);

      load(4'd6, 32'hFFFF_FFF9, 32'd2, 5'd11);
      rd(5'd11);
      chk_entry("div", 4'd6, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0);

      load(4'd7, 32'hFFFF_FFF9, 32'd2, 5'd12);
      rd(5'd12);
      chk_entry("mod", 4'd7, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);

      load(4'd6, 32'd9, 32'd0, 5'd13);
      rd(5'd13);
      chk_entry("div0", 4'd6, 32'd9, 32'd0, 64'd0, 1'b1);

      load(4'd9, 32'd4, 32'd4, 5'd14);
      rd(5'd14);
      chk_entry("resv", 4'd9, 32'd4, 32'd4, 64'd0, 1'b1);
      chk_cnt("arith.cnt", 6);

      // read_en low: outputs hold the last read
      bus.read_pointer = 5'd2;
      step();
      chk_entry("hold", 4'd9, 32'd4, 32'd4, 64'd0, 1'b1);

      // Read issued on the same edge the entry-4 write commits.
      load(4'd4, 32'd10, 32'd3, 5'd4);
      rd(5'd4);
      chk_entry("bypass", 4'd4, 32'd10, 32'd3, 64'd7, 1'b0);
      chk_cnt("bypass.cnt", 7);

      rd(5'd5);
      chk_empty("unwritten");

      rd(5'd2);
      chk_entry("add.stored", 4'd3, 32'd5, 32'hFFFF_FFFD, 64'd2, 1'b0);

      for (int i = 0; i < 32; i++) begin
         bus.load_en       = 1'b1;
         bus.opcode        = 4'd1;
         bus.operand_a     = 32'(i * 3 - 40);
         bus.operand_b     = 32'(i);
         bus.write_pointer = 5'(i);
         step();
      end
      bus.load_en = 1'b0;
      step();
      chk_cnt("fill.cnt", 32);
      rd(5'd31);
      chk_entry("fill.e31", 4'd1, 32'd53, 32'd31, 64'd53, 1'b0);
      rd(5'd0);
      chk_entry("fill.e0", 4'd1, 32'hFFFF_FFD8, 32'd0, 64'hFFFF_FFFF_FFFF_FFD8, 1'b0);

      load(4'd2, 32'd8, 32'hFFFF_FFFF, 5'd0);
      step();
      chk_cnt("ovw.cnt", 32);
      rd(5'd0);
      chk_entry("ovw.e0", 4'd2, 32'd8, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);

      // Back-to-back loads to the same entry: second one wins.
      bus.load_en       = 1'b1;
      bus.opcode        = 4'd3;
      bus.operand_a     = 32'd1;
      bus.operand_b     = 32'd1;
      bus.write_pointer = 5'd20;
      step();
      bus.opcode    = 4'd5;
      bus.operand_a = 32'd3;
      bus.operand_b = 32'd4;
      step();
      bus.load_en = 1'b0;
      step();
      rd(5'd20);
      chk_entry("lww", 4'd5, 32'd3, 32'd4, 64'd12, 1'b0);
      chk_cnt("lww.cnt", 32);

      #2 reset = 1'b1;
      #1;
      chk_empty("rst2");
      chk_cnt("rst2.cnt", 0);
      #2 reset = 1'b0;
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
